sram_dumper: RTL and testbench



---
 rtl/sram_dumper.sv | 181 ++++++++++++++++++
 tb/tb_sram_dumper.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_dumper.sv
// sram_dumper: unloads a dual-port SRAM and streams every word, tagged with its
// address, over a valid/ready interface. When the last word is taken it raises
// dump_irq, which stays high until irq_ack.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   enable              start request (only looked at in IDLE)
//   irq_ack             interrupt acknowledge (only looked at in DONE)
//   dump_irq            done interrupt
//   ce/we/addr/wmask/wdata_{a,b}, rdata_{a,b}
//                       SRAM port pair: read-only, data returns one cycle after ce
//   out_valid/out_ready/out_data/out_addr
//                       output word stream
//   nz_cnt, nz_err      count of nonzero words streamed, and whether any were
//                       seen (present only with SRAM_DUMPER_ZERO_CHECK_EN)
//
// Optional feature macro: SRAM_DUMPER_ZERO_CHECK_EN
//
// Port A reads the low half of the memory and port B the high half, in
// lockstep. Both words land in a 4-entry FIFO together, A ahead of B. The
// stream order is therefore 0, D/2, 1, D/2+1, ...
module sram_dumper #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               irq_ack,
  output logic               dump_irq,
  output logic               ce_a,
  output logic               ce_b,
  output logic               we_a,
  output logic               we_b,
  output logic [AW-1:0]      addr_a,
  output logic [AW-1:0]      addr_b,
  output logic [WIDTH/8-1:0] wmask_a,
  output logic [WIDTH/8-1:0] wmask_b,
  output logic [WIDTH-1:0]   wdata_a,
  output logic [WIDTH-1:0]   wdata_b,
  input  logic [WIDTH-1:0]   rdata_a,
  input  logic [WIDTH-1:0]   rdata_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [AW-1:0]      out_addr
`ifdef SRAM_DUMPER_ZERO_CHECK_EN
  ,
  output logic [AW:0]        nz_cnt,
  output logic               nz_err
`endif
);

  localparam logic [AW-1:0] HALF = AW'(DEPTH / 2);
  localparam logic [AW-1:0] LAST = AW'(DEPTH / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic [AW-1:0]          fidx_q, fidx_d;       // idx of the read in flight
  logic                   inflight_q, inflight_d;
  logic [3:0][WIDTH-1:0]  fdata_q, fdata_d;
  logic [3:0][AW-1:0]     faddr_q, faddr_d;
  logic [1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0]             wptr_nx;
  logic [2:0]             cnt_q, cnt_d;
  logic                   irq_q, irq_d;
  logic                   issue, pop;
`ifdef SRAM_DUMPER_ZERO_CHECK_EN
  logic [AW:0]            nz_cnt_q, nz_cnt_d;
`endif

  // Issue only if the FIFO can hold everything already stored plus the pair
  // landing this cycle plus the new pair, without counting pops. Four
  // entries are then always enough.
  assign issue = (state_q == S_READ) &&
                 (inflight_q ? (cnt_q == 3'd0) : (cnt_q <= 3'd2));
  assign pop   = (cnt_q != 3'd0) && out_ready;

  assign ce_a      = issue;
  assign ce_b      = issue;
  assign we_a      = 1'b0;
  assign we_b      = 1'b0;
  assign wmask_a   = '0;
  assign wmask_b   = '0;
  assign wdata_a   = '0;
  assign wdata_b   = '0;
  assign addr_a    = idx_q;
  assign addr_b    = idx_q + HALF;
  assign out_valid = (cnt_q != 3'd0);
  assign out_data  = fdata_q[rptr_q];
  assign out_addr  = faddr_q[rptr_q];
  assign dump_irq  = irq_q;
`ifdef SRAM_DUMPER_ZERO_CHECK_EN
  assign nz_cnt    = nz_cnt_q;
  assign nz_err    = (nz_cnt_q != '0);
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    irq_d      = irq_q;
    inflight_d = issue;
    fidx_d     = issue ? idx_q : fidx_q;
    fdata_d    = fdata_q;
    faddr_d    = faddr_q;
    wptr_nx    = wptr_q + 2'd1;
    wptr_d     = wptr_q + (inflight_q ? 2'd2 : 2'd0);
    rptr_d     = rptr_q + {1'b0, pop};
    cnt_d      = cnt_q + (inflight_q ? 3'd2 : 3'd0) - {2'b00, pop};
`ifdef SRAM_DUMPER_ZERO_CHECK_EN
    nz_cnt_d   = nz_cnt_q + {{AW{1'b0}}, (pop && (out_data != '0))};
`endif

    // A pair of read words lands at the end of the cycle after its issue.
    if (inflight_q) begin
      fdata_d[wptr_q]  = rdata_a;
      faddr_d[wptr_q]  = fidx_q;
      fdata_d[wptr_nx] = rdata_b;
      faddr_d[wptr_nx] = fidx_q + HALF;
    end

    case (state_q)
      S_IDLE: if (enable) begin
        state_d  = S_READ;
        idx_d    = '0;
`ifdef SRAM_DUMPER_ZERO_CHECK_EN
        nz_cnt_d = '0;
`endif
      end
      S_READ: if (issue) begin
        if (idx_q == LAST) state_d = S_DRAIN;
        else               idx_d   = idx_q + 1'b1;
      end
      S_DRAIN: if (pop && (cnt_q == 3'd1) && !inflight_q) begin
        state_d = S_DONE;
        irq_d   = 1'b1;
      end
      S_DONE: if (irq_ack) begin
        state_d = S_IDLE;
        irq_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      fidx_q     <= '0;
      inflight_q <= 1'b0;
      fdata_q    <= '0;
      faddr_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      irq_q      <= 1'b0;
`ifdef SRAM_DUMPER_ZERO_CHECK_EN
      nz_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      fidx_q     <= fidx_d;
      inflight_q <= inflight_d;
      fdata_q    <= fdata_d;
      faddr_q    <= faddr_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      irq_q      <= irq_d;
`ifdef SRAM_DUMPER_ZERO_CHECK_EN
      nz_cnt_q   <= nz_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_sram_dumper.sv
// Bench for sram_dumper (DEPTH=16, WIDTH=32). A behavioural SRAM answers the
// reads. The reference model gives the expected stream order from the word
// index (even k -> k/2, odd k -> k/2+D/2). It also tracks FIFO occupancy as
// (words landed - words taken) to check the issue rule.
module tb_sram_dumper;
  localparam int DEPTH = 16;
  localparam int WIDTH = 32;
  localparam int AW    = 4;
  localparam int H     = DEPTH / 2;

  logic clk = 1'b0;
  logic rst = 1'b1, enable = 1'b0, irq_ack = 1'b0, out_ready = 1'b1;
  logic dump_irq, ce_a, ce_b, we_a, we_b, out_valid;
  logic [AW-1:0] addr_a, addr_b, out_addr;
  logic [WIDTH/8-1:0] wmask_a, wmask_b;
  logic [WIDTH-1:0] wdata_a, wdata_b, out_data;
  logic [WIDTH-1:0] rdata_a = '0, rdata_b = '0;
`ifdef SRAM_DUMPER_ZERO_CHECK_EN
  logic [AW:0] nz_cnt;
  logic nz_err;
`endif

  logic [WIDTH-1:0] mem [DEPTH];

  sram_dumper #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .irq_ack(irq_ack), .dump_irq(dump_irq),
    .ce_a(ce_a), .ce_b(ce_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wmask_a(wmask_a), .wmask_b(wmask_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr)
`ifdef SRAM_DUMPER_ZERO_CHECK_EN
    , .nz_cnt(nz_cnt), .nz_err(nz_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ce_a) rdata_a <= mem[addr_a];
    if (ce_b) rdata_b <= mem[addr_b];
  end

  int n_chk = 0, n_fail = 0;
  int occ = 0, words = 0;
  logic prev_ce = 1'b0, prev_stall = 1'b0, prev_irq = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  logic [AW-1:0] prev_addr = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Check the current cycle against the model, then advance one clock.
  task automatic step();
    logic hs, landing, cur_ce;
    if (!rst) begin
      if (ce_a || ce_b) begin
        chk("ce_pair", {63'd0, ce_b}, {63'd0, ce_a});
        chk("issue_rule", {63'd0, (occ + (prev_ce ? 2 : 0)) <= 2}, 64'd1);
      end
      chk("write_off", {63'd0, we_a | we_b | (|wmask_a) | (|wmask_b) | (|wdata_a) | (|wdata_b)}, 64'd0);
      if (prev_stall) begin
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_data", 64'(out_data), 64'(prev_data));
        chk("stall_addr", 64'(out_addr), 64'(prev_addr));
      end
      if (out_valid && out_ready) begin
        int a;
        a = (words % 2 == 0) ? words / 2 : words / 2 + H;
        chk("word_addr", 64'(out_addr), 64'(a));
        chk("word_data", 64'(out_data), 64'(mem[a]));
        words++;
      end
      if (dump_irq && !prev_irq) chk("word_count", 64'(words), 64'(DEPTH));
      if (dump_irq && irq_ack) words = 0;
    end
    hs         = out_valid && out_ready && !rst;
    landing    = prev_ce;
    cur_ce     = ce_a && !rst;
    prev_stall = out_valid && !out_ready && !rst;
    prev_data  = out_data;
    prev_addr  = out_addr;
    prev_irq   = dump_irq && !rst;
    @(posedge clk); #1;
    if (rst) begin
      occ = 0; prev_ce = 1'b0; words = 0; prev_stall = 1'b0; prev_irq = 1'b0;
    end else begin
      occ = occ + (landing ? 2 : 0) - (hs ? 1 : 0);
      prev_ce = cur_ce;
      chk("fifo_bound", {63'd0, occ <= 4}, 64'd1);
    end
  endtask

  task automatic wait_irq(input string tag);
    int t = 0;
    while (!dump_irq && t < 1000) begin step(); t++; end
    chk(tag, {63'd0, dump_irq}, 64'd1);
  endtask

  task automatic ack();
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("ack_irq_low", {63'd0, dump_irq}, 64'd0);
  endtask

  task automatic pulse_enable();
    enable = 1'b1; step(); enable = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i + 32'h100);
    #1;
    step(); step();
    // reset values
    chk("rst_irq", {63'd0, dump_irq}, 64'd0);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_ce", {62'd0, ce_a, ce_b}, 64'd0);
    chk("rst_we", {62'd0, we_a, we_b}, 64'd0);
    chk("rst_addr_a", 64'(addr_a), 64'd0);
    chk("rst_addr_b", 64'(addr_b), 64'(H));
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_addr", 64'(out_addr), 64'd0);
    rst = 1'b0;
    step();

    // reference timing, out_ready held high; enable pulsed in cycle 0
    enable = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      if (c <= 1) chk("t_ce", {63'd0, ce_a}, {63'd0, c == 1});
      chk("t_valid", {63'd0, out_valid}, {63'd0, c >= 3 && c <= 3 + DEPTH - 1});
      chk("t_irq", {63'd0, dump_irq}, {63'd0, c >= 3 + DEPTH});
      step();
      enable = 1'b0;
    end

    // irq held until acknowledged
    for (int c = 0; c < 10; c++) begin
      chk("irq_hold", {63'd0, dump_irq}, 64'd1);
      step();
    end
    ack();
    for (int c = 0; c < 3; c++) begin
      chk("idle_ce", {63'd0, ce_a}, 64'd0);
      chk("idle_valid", {63'd0, out_valid}, 64'd0);
      step();
    end

    // random data, out_ready at ~30% duty, stray enable pulses mid-dump
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    pulse_enable();
    for (int t = 0; t < 2000 && !dump_irq; t++) begin
      out_ready = ($urandom_range(0, 99) < 30);
      enable    = ($urandom_range(0, 9) == 0);
      step();
      enable    = 1'b0;
    end
    chk("rand_done", {63'd0, dump_irq}, 64'd1);
    out_ready = 1'b1;
    ack();

    // reset after 5 words, then restart from address 0
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    pulse_enable();
    for (int t = 0; t < 100 && words < 5; t++) step();
    chk("five_words", 64'(words), 64'd5);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_ce", {62'd0, ce_a, ce_b}, 64'd0);
    chk("mid_rst_irq", {63'd0, dump_irq}, 64'd0);
    step(); step();
    chk("post_rst_valid", {63'd0, out_valid}, 64'd0);
    pulse_enable();
    wait_irq("restart_done");
    ack();

    // enable held through DONE and ack: one dump per IDLE entry
    enable = 1'b1;
    wait_irq("held_done1");
    for (int c = 0; c < 5; c++) begin
      chk("done_no_ce", {63'd0, ce_a}, 64'd0);
      chk("done_irq", {63'd0, dump_irq}, 64'd1);
      step();
    end
    ack();
    wait_irq("held_done2");
    enable = 1'b0;
    ack();
    for (int c = 0; c < 5; c++) begin
      chk("final_idle_ce", {63'd0, ce_a}, 64'd0);
      step();
    end

`ifdef SRAM_DUMPER_ZERO_CHECK_EN
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    mem[5] = 32'hDEAD;
    pulse_enable();
    wait_irq("nz_done1");
    chk("nz_cnt_one", 64'(nz_cnt), 64'd1);
    chk("nz_err_one", {63'd0, nz_err}, 64'd1);
    ack();
    mem[5] = '0;
    pulse_enable();
    wait_irq("nz_done0");
    chk("nz_cnt_zero", 64'(nz_cnt), 64'd0);
    chk("nz_err_zero", {63'd0, nz_err}, 64'd0);
    ack();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
